// File: rtl/suffix_padder_unit.sv
// ============================================================================
//  Module      : suffix_padder_unit
//  Description : XOR-overlays the Keccak domain suffix and pad10*1 final bit
//                onto the 1600-bit state of the last absorb block, 1-cycle reg.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module suffix_padder_unit #(
    parameter int ROW_SIZE          = 5,
    parameter int COL_SIZE          = 5,
    parameter int LANE_SIZE         = 64,
    parameter int RATE_WIDTH        = 11,
    parameter int BYTE_ABSORB_WIDTH = 8,
    parameter int SUFFIX_WIDTH      = 8
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic                                               valid_i,
    input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0]   state_array_i,
    input  logic [RATE_WIDTH-1:0]                              rate_i,
    input  logic [BYTE_ABSORB_WIDTH-1:0]                       bytes_absorbed_i,
    input  logic [SUFFIX_WIDTH-1:0]                            suffix_i,
    output logic                                               valid_o,
    output logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0]   state_array_o
);

    localparam int c_LANE_BYTES = LANE_SIZE / 8;
    localparam int c_LANE_LOG2  = $clog2(LANE_SIZE);
    localparam int c_IDX_W      = 16;

    logic                  w_rate_ok;
    logic                  w_head_en;
    logic [c_IDX_W-1:0]    w_rate_bytes;
    logic [c_IDX_W-1:0]    w_head_idx;
    logic [c_IDX_W-1:0]    w_tail_idx;
    logic [7:0]            w_suffix_byte;

    logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] w_state_next;
    logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] r_state;
    logic                                             r_valid;

    // Padding only makes sense for a non-zero, lane-aligned rate.
    assign w_rate_ok     = (rate_i != '0) && (rate_i[c_LANE_LOG2-1:0] == '0);
    assign w_rate_bytes  = c_IDX_W'(rate_i >> 3);
    assign w_head_idx    = c_IDX_W'(bytes_absorbed_i);
    assign w_tail_idx    = w_rate_bytes - c_IDX_W'(1);
    assign w_head_en     = w_rate_ok && (w_head_idx < w_rate_bytes);
    assign w_suffix_byte = 8'(suffix_i);

    // Every state byte compares itself against head/tail; indices past the
    // last lane simply match no byte, so they are dropped for free.
    for (genvar gx = 0; gx < ROW_SIZE; gx++) begin : g_x
        for (genvar gy = 0; gy < COL_SIZE; gy++) begin : g_y
            for (genvar gk = 0; gk < c_LANE_BYTES; gk++) begin : g_k
                localparam logic [c_IDX_W-1:0] c_BYTE_IDX =
                    c_IDX_W'((gy * ROW_SIZE + gx) * c_LANE_BYTES + gk);

                logic [7:0] w_head_byte;
                logic [7:0] w_tail_byte;

                assign w_head_byte = (w_head_en && (w_head_idx == c_BYTE_IDX))
                                     ? w_suffix_byte : 8'h00;
                assign w_tail_byte = (w_rate_ok && (w_tail_idx == c_BYTE_IDX))
                                     ? 8'h80 : 8'h00;
                assign w_state_next[gx][gy][8*gk +: 8] =
                    state_array_i[gx][gy][8*gk +: 8] ^ w_head_byte ^ w_tail_byte;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= valid_i;
            if (valid_i) begin
                r_state <= w_state_next;
            end
        end
    end

    assign state_array_o = r_state;
    assign valid_o       = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_suffix_padder_unit.sv
// ============================================================================
//  Module      : tb_suffix_padder_unit
//  Description : Self-checking bench for suffix_padder_unit: directed cases
//                plus randomized traffic against a byte-array reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_suffix_padder_unit;

    typedef logic [4:0][4:0][63:0] state_t;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    state_t      state_array_i;
    logic [10:0] rate_i;
    logic [7:0]  bytes_absorbed_i;
    logic [7:0]  suffix_i;
    logic        valid_o;
    state_t      state_array_o;

    int     n_checks;
    int     n_fail;
    state_t exp_hold;

    suffix_padder_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .valid_i          (valid_i),
        .state_array_i    (state_array_i),
        .rate_i           (rate_i),
        .bytes_absorbed_i (bytes_absorbed_i),
        .suffix_i         (suffix_i),
        .valid_o          (valid_o),
        .state_array_o    (state_array_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: state viewed as a flat 200-byte message buffer.
    function automatic state_t model(state_t s, logic [10:0] rate, logic [7:0] h, logic [7:0] suf);
        logic [7:0] m [200];
        state_t     r;
        int         nb;
        for (int b = 0; b < 200; b++) begin
            m[b] = s[(b/8)%5][(b/8)/5][8*(b%8) +: 8];
        end
        nb = int'(rate) / 8;
        if (rate != 0 && (int'(rate) % 64) == 0) begin
            if (int'(h) < nb && int'(h) < 200) m[int'(h)] ^= suf;
            if (nb - 1 < 200) m[nb-1] ^= 8'h80;
        end
        for (int b = 0; b < 200; b++) begin
            r[(b/8)%5][(b/8)/5][8*(b%8) +: 8] = m[b];
        end
        return r;
    endfunction

    function automatic string diff_msg(state_t a, state_t e);
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                if (a[x][y] !== e[x][y])
                    return $sformatf("lane[%0d][%0d] got %h want %h", x, y, a[x][y], e[x][y]);
        return "no lane differs";
    endfunction

    function automatic state_t rand_state();
        state_t s;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                s[x][y] = {$urandom, $urandom};
        return s;
    endfunction

    task automatic drive(input logic v, input state_t s, input logic [10:0] r,
                         input logic [7:0] h, input logic [7:0] suf);
        valid_i          = v;
        state_array_i    = s;
        rate_i           = r;
        bytes_absorbed_i = h;
        suffix_i         = suf;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, '1, 11'd1088, 8'd0, 8'h06);
        #2;
        n_checks++;
        if (state_array_o !== '0 || valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: valid_o=%b %s", valid_o, diff_msg(state_array_o, '0));
        end
        @(posedge clk); #1;
        n_checks++;
        if (state_array_o !== '0 || valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: valid_o=%b %s", valid_o, diff_msg(state_array_o, '0));
        end
        valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_hold = '0;
    endtask

    task automatic test_split();
        state_t e;
        e = '0;
        e[1][0] = 64'h0000000000000006;
        e[1][3] = 64'h8000000000000000;
        drive(1'b1, '0, 11'd1088, 8'd8, 8'h06);
        @(posedge clk); #1;
        n_checks++;
        if (state_array_o !== e || valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL split: valid_o=%b %s", valid_o, diff_msg(state_array_o, e));
        end
        exp_hold = e;
    endtask

    task automatic test_merged();
        state_t e;
        e = '0;
        e[1][3] = 64'h8600000000000000;
        drive(1'b1, '0, 11'd1088, 8'd135, 8'h06);
        @(posedge clk); #1;
        n_checks++;
        if (state_array_o !== e || valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL merged: valid_o=%b %s", valid_o, diff_msg(state_array_o, e));
        end
        exp_hold = e;
    endtask

    task automatic test_shake();
        state_t e;
        e = '0;
        e[0][0] = 64'h000000000000001F;
        e[0][4] = 64'h8000000000000000;
        drive(1'b1, '0, 11'd1344, 8'd0, 8'h1F);
        @(posedge clk); #1;
        n_checks++;
        if (state_array_o !== e || valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL shake_spill: valid_o=%b %s", valid_o, diff_msg(state_array_o, e));
        end
        exp_hold = e;
    endtask

    task automatic test_xor_preserve();
        state_t e;
        e = '1;
        e[0][0] = 64'hFFFFFFFFFFFFFFF9;
        e[1][3] = 64'h7FFFFFFFFFFFFFFF;
        drive(1'b1, '1, 11'd1088, 8'd0, 8'h06);
        @(posedge clk); #1;
        n_checks++;
        if (state_array_o !== e || valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL xor_preserve: valid_o=%b %s", valid_o, diff_msg(state_array_o, e));
        end
        exp_hold = e;
    endtask

    task automatic test_out_of_range();
        state_t e;
        e = '0;
        e[1][3] = 64'h8000000000000000;
        drive(1'b1, '0, 11'd1088, 8'd140, 8'h06);
        @(posedge clk); #1;
        n_checks++;
        if (state_array_o !== e || valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL head_out_of_range: valid_o=%b %s", valid_o, diff_msg(state_array_o, e));
        end
        exp_hold = e;
    endtask

    task automatic test_bad_rate();
        state_t s;
        logic [10:0] rates [3];
        rates[0] = 11'd0;
        rates[1] = 11'd1000;
        rates[2] = 11'd1090;
        foreach (rates[i]) begin
            s = rand_state();
            drive(1'b1, s, rates[i], 8'd3, 8'h06);
            @(posedge clk); #1;
            n_checks++;
            if (state_array_o !== s) begin
                n_fail++;
                $display("FAIL bad_rate_%0d: %s", rates[i], diff_msg(state_array_o, s));
            end
            exp_hold = s;
        end
    endtask

    task automatic test_hold();
        drive(1'b0, rand_state(), 11'd1088, 8'd5, 8'h1F);
        @(posedge clk); #1;
        n_checks++;
        if (valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_valid: got %b want 0", valid_o);
        end
        n_checks++;
        if (state_array_o !== exp_hold) begin
            n_fail++;
            $display("FAIL hold_state: %s", diff_msg(state_array_o, exp_hold));
        end
    endtask

    task automatic test_reset_mid();
        state_t s;
        s = rand_state();
        drive(1'b1, s, 11'd1344, 8'd17, 8'h1F);
        @(posedge clk); #1;
        n_checks++;
        if (state_array_o !== model(s, 11'd1344, 8'd17, 8'h1F) || valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: valid_o=%b %s", valid_o,
                     diff_msg(state_array_o, model(s, 11'd1344, 8'd17, 8'h1F)));
        end
        drive(1'b1, rand_state(), 11'd1088, 8'd2, 8'h06);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (state_array_o !== '0 || valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: valid_o=%b %s", valid_o, diff_msg(state_array_o, '0));
        end
        @(posedge clk); #1;
        n_checks++;
        if (state_array_o !== '0 || valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_drop: valid_o=%b %s", valid_o, diff_msg(state_array_o, '0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        s = rand_state();
        drive(1'b1, s, 11'd1088, 8'd135, 8'h06);
        @(posedge clk); #1;
        exp_hold = model(s, 11'd1088, 8'd135, 8'h06);
        n_checks++;
        if (state_array_o !== exp_hold || valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL first_capture: valid_o=%b %s", valid_o, diff_msg(state_array_o, exp_hold));
        end
    endtask

    task automatic test_back_to_back();
        state_t      s;
        logic [10:0] r;
        logic [7:0]  h;
        logic [7:0]  suf;
        logic        v;
        logic [10:0] rate_pool [8];
        rate_pool[0] = 11'd1088; rate_pool[1] = 11'd1344; rate_pool[2] = 11'd1152;
        rate_pool[3] = 11'd832;  rate_pool[4] = 11'd576;  rate_pool[5] = 11'd1600;
        rate_pool[6] = 11'd1984; rate_pool[7] = 11'd64;
        for (int i = 0; i < 300; i++) begin
            s   = rand_state();
            v   = (i == 0) ? 1'b1 : ($urandom_range(3, 0) != 0);
            r   = ($urandom_range(7, 0) == 0) ? 11'($urandom) : rate_pool[$urandom_range(7, 0)];
            h   = ($urandom_range(1, 0) == 0) ? 8'($urandom) : 8'(int'(r) / 8 - 1);
            suf = ($urandom_range(1, 0) == 0) ? 8'($urandom) : 8'h06;
            drive(v, s, r, h, suf);
            @(posedge clk); #1;
            if (v) exp_hold = model(s, r, h, suf);
            n_checks++;
            if (valid_o !== v || state_array_o !== exp_hold) begin
                n_fail++;
                $display("FAIL random_%0d: rate=%0d h=%0d suf=%h valid_o=%b want %b %s",
                         i, r, h, suf, valid_o, v, diff_msg(state_array_o, exp_hold));
            end
        end
        valid_i = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_hold = '0;
        test_reset();
        test_split();
        test_merged();
        test_shake();
        test_xor_preserve();
        test_out_of_range();
        test_hold();
        test_bad_rate();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
